toggle_event_rx: RTL

//   Receiving end of a toggle-encoded event link. A transmitter (T flip-flop,
//   Q resets to 0) flips its line once per event. This block recovers those events.
//   - synchronises the line into clk; each level change becomes one event
//   - queues events in a saturating pending counter, drained by a valid/ready handshake
//   - sits at the destination of any toggle-signalled event crossing

---
 rtl/toggle_rx_pkg.sv | 32 +++
 rtl/toggle_sync.sv | 26 ++
 rtl/toggle_event_rx.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/toggle_rx_pkg.sv
// Shared definitions for the toggle-event receiver: synchroniser depth
// limits, a constant-safe clog2 for sizing counters, and the handshake
// state encoding used to describe the pending queue.
package toggle_rx_pkg;

    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

    // Coarse view of the pending queue, derived from the event count
    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        FULL
    } hsState_t;

    // Bits needed to hold the values 0 .. value-1; never returns less than 1
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser bringing an asynchronous level into the clock
// domain. The chain resets to 0 so a freshly reset receiver sees the same
// idle level as a freshly reset transmitter.
module toggle_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the raw line through the chain; the last flop is the safe copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Receiving end of a toggle-encoded event link. Every level change on T_in
// becomes one event: a one-cycle pulse plus an entry in a saturating pending
// counter that a consumer drains through a valid/ready handshake. Events that
// arrive while the counter is full are dropped and flagged in a sticky
// overflow bit.
// Optional build macro: TOGGLE_RX_GLITCH_FILTER_EN adds a stability filter
// that only accepts a new level after FILTER_LEN consecutive cycles.
module toggle_event_rx
    import toggle_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_PEND    = 7,
    parameter int FILTER_LEN  = 3
) (
    input  logic                            clk,
    input  logic                            Reset,
    input  logic                            T_in,
    output logic                            evt_pulse,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [clog2(MAX_PEND+1)-1:0]    pend_count,
    output logic                            overflow,
    input  logic                            overflow_clr
);

    localparam int CW = clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PEND);

    // Reject configurations the design was not built for
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_badSync
        $error("toggle_event_rx: SYNC_STAGES out of range");
    end
    if (FILTER_LEN < 1) begin : g_badFilter
        $error("toggle_event_rx: FILTER_LEN must be at least 1");
    end

    logic          w_sync;
    logic          w_differ;
    logic          w_event;
    logic          w_dec;
    logic          w_setOvf;
    logic          r_acc;
    logic          r_pulse;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    hsState_t      w_hsState;

    toggle_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (Reset),
        .i_d (T_in),
        .o_q (w_sync)
    );

    assign w_differ = (w_sync != r_acc);

`ifdef TOGGLE_RX_GLITCH_FILTER_EN
    localparam int FW = clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FILTER_CNT = FW'(FILTER_LEN);

    logic [FW-1:0] r_stable;

    // A new level is accepted only once it has persisted FILTER_LEN cycles
    assign w_event = w_differ && (r_stable == FILTER_CNT);

    // Count consecutive cycles of disagreement; any return or acceptance restarts it
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_stable <= '0;
        end else if (w_differ && !w_event) begin
            r_stable <= r_stable + FW'(1);
        end else begin
            r_stable <= '0;
        end
    end
`else
    // Without the filter, any disagreement with the accepted level is an event
    assign w_event = w_differ;
`endif

    assign w_dec    = evt_valid && evt_ready;
    assign w_setOvf = w_event && !w_dec && (r_count == MAX_CNT);

    // Track the accepted line level and strobe once per accepted change
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_acc   <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_event;
            if (w_event) begin
                r_acc <= w_sync;
            end
        end
    end

    // Saturating queue of events; simultaneous arrival and consumption cancel
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (w_event && !w_dec) begin
            if (r_count != MAX_CNT) begin
                r_count <= r_count + CW'(1);
            end
        end else if (!w_event && w_dec) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Sticky record of dropped events; a new drop beats a same-cycle clear
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_ovf <= 1'b0;
        end else if (w_setOvf) begin
            r_ovf <= 1'b1;
        end else if (overflow_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Describe the queue occupancy for debug visibility and the checks below
    always_comb begin
        w_hsState = IDLE;
        if (r_count == MAX_CNT) begin
            w_hsState = FULL;
        end else if (r_count != '0) begin
            w_hsState = PENDING;
        end
    end

    // Nothing may be consumed from an empty queue, and the count never exceeds its limit
    assert property (@(posedge clk) disable iff (Reset) !(w_dec && w_hsState == IDLE));
    assert property (@(posedge clk) disable iff (Reset) r_count <= MAX_CNT);

    assign evt_pulse  = r_pulse;
    assign evt_valid  = (r_count != '0);
    assign pend_count = r_count;
    assign overflow   = r_ovf;

endmodule
